// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters, with a tag
// pipeline that routes each product back to its issuer. Define MULT_SHARE_ARB_PRIO_EN for fixed priority.
module mult_share_arb #(
    parameter int bw   = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*bw-1:0]        req_A,
    input  logic [NREQ*bw-1:0]        req_B,
    output logic [bw-1:0]             mul_A,
    output logic [bw-1:0]             mul_B,
    input  logic [2*bw-1:0]           mul_out,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [2*bw-1:0]           rsp_data,
    output logic [$clog2(LAT+1):0]    inflight
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(LAT+1) + 1;

    logic                     grant_any;
    logic [IDW-1:0]           grant_id;
    logic                     issue;

    logic [LAT-1:0]           vld_q, vld_d;
    logic [LAT-1:0][IDW-1:0]  id_q, id_d;
    logic [CW-1:0]            inflight_q, inflight_d;

`ifndef MULT_SHARE_ARB_PRIO_EN
    logic [IDW-1:0]           ptr_q, ptr_d;
`endif

    always_comb begin : arb
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
`ifdef MULT_SHARE_ARB_PRIO_EN
            idx = off;
`else
            idx = (32'(ptr_q) + off) % NREQ;
`endif
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end

        // Ready is gated by reset so nothing can hand off while the tags are held clear.
        issue     = grant_any & RESETn;
        req_ready = '0;
        mul_A     = '0;
        mul_B     = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            mul_A = req_A[grant_id*bw +: bw];
            mul_B = req_B[grant_id*bw +: bw];
        end

`ifndef MULT_SHARE_ARB_PRIO_EN
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = IDW'((32'(grant_id) + 1) % NREQ);
        end
`endif
    end

    always_comb begin : tags
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = issue;
        id_d[0]  = grant_id;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
        end
    end

    always_comb begin : rsp
        rsp_valid = '0;
        if (vld_q[LAT-1]) begin
            rsp_valid[id_q[LAT-1]] = 1'b1;
        end
        // The product still counts as in flight during its response cycle.
        inflight_d = inflight_q + CW'(issue) - CW'(vld_q[LAT-1]);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_q      <= '0;
            id_q       <= '0;
            inflight_q <= '0;
`ifndef MULT_SHARE_ARB_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            vld_q      <= vld_d;
            id_q       <= id_d;
            inflight_q <= inflight_d;
`ifndef MULT_SHARE_ARB_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign rsp_data = mul_out;
    assign inflight = inflight_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: a LAT=1 and a LAT=3 instance, each with a multiplier
// model, and a scoreboard of expected responses checked every cycle.
module tb_mult_share_arb;

    localparam int BW = 16;
    localparam int NR = 4;

    typedef struct {
        int unsigned ie;
        int unsigned id;
        logic [31:0] prod;
    } sb_t;

    logic CLK    = 1'b0;
    logic RESETn = 1'b1;

    logic [NR-1:0]    vld  [2];
    logic [NR-1:0]    rdy  [2];
    logic [NR-1:0]    rspv [2];
    logic [NR*BW-1:0] ra   [2];
    logic [NR*BW-1:0] rb   [2];
    logic [BW-1:0]    ma   [2];
    logic [BW-1:0]    mb   [2];
    logic [2*BW-1:0]  mo   [2];
    logic [2*BW-1:0]  rd   [2];
    logic [1:0]       inf1;
    logic [2:0]       inf3;
    logic [2*BW-1:0]  p1_q;
    logic [2*BW-1:0]  p3_q [3];

    sb_t         sbq [2][$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 CLK = ~CLK;

    mult_share_arb #(.bw(BW), .NREQ(NR), .LAT(1)) u_dut1 (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(vld[0]), .req_ready(rdy[0]), .req_A(ra[0]), .req_B(rb[0]),
        .mul_A(ma[0]), .mul_B(mb[0]), .mul_out(mo[0]),
        .rsp_valid(rspv[0]), .rsp_data(rd[0]), .inflight(inf1)
    );

    mult_share_arb #(.bw(BW), .NREQ(NR), .LAT(3)) u_dut3 (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(vld[1]), .req_ready(rdy[1]), .req_A(ra[1]), .req_B(rb[1]),
        .mul_A(ma[1]), .mul_B(mb[1]), .mul_out(mo[1]),
        .rsp_valid(rspv[1]), .rsp_data(rd[1]), .inflight(inf3)
    );

    // Shared multiplier models: output-registered, reset with the arbiter.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            p1_q    <= '0;
            p3_q[0] <= '0;
            p3_q[1] <= '0;
            p3_q[2] <= '0;
        end else begin
            p1_q    <= {16'b0, ma[0]} * {16'b0, mb[0]};
            p3_q[0] <= {16'b0, ma[1]} * {16'b0, mb[1]};
            p3_q[1] <= p3_q[0];
            p3_q[2] <= p3_q[1];
        end
    end

    assign mo[0] = p1_q;
    assign mo[1] = p3_q[2];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response / inflight monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RESETn) begin
            for (int d = 0; d < 2; d++) begin
                logic [NR-1:0] ev;
                logic [31:0]   ed;
                int unsigned   ei;
                int unsigned   lat;
                lat = (d == 0) ? 1 : 3;
                ev  = '0;
                ed  = '0;
                ei  = 0;
                for (int k = 0; k < sbq[d].size(); k++) begin
                    if (sbq[d][k].ie <= cyc && cyc <= sbq[d][k].ie + lat - 1) ei++;
                end
                if (sbq[d].size() > 0 && sbq[d][0].ie + lat - 1 == cyc) begin
                    ev = NR'(1) << sbq[d][0].id;
                    ed = sbq[d][0].prod;
                    void'(sbq[d].pop_front());
                end
                chk($sformatf("dut%0d rsp_valid cyc%0d", d, cyc), 64'(rspv[d]), 64'(ev));
                if (ev != '0) chk($sformatf("dut%0d rsp_data cyc%0d", d, cyc), 64'(rd[d]), 64'(ed));
                chk($sformatf("dut%0d inflight cyc%0d", d, cyc),
                    (d == 0) ? 64'(inf1) : 64'(inf3), 64'(ei));
            end
        end
    end

    function automatic logic [NR*BW-1:0] pack4(input logic [15:0] x0, input logic [15:0] x1,
                                               input logic [15:0] x2, input logic [15:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic step(input int d, input logic [NR-1:0] v, input logic [NR*BW-1:0] a,
                        input logic [NR*BW-1:0] b, input logic [NR-1:0] exp_rdy, input string tag);
        int            id;
        logic [BW-1:0] ea, eb;
        sb_t           e;
        @(posedge CLK);
        #1;
        vld[d] = v;
        ra[d]  = a;
        rb[d]  = b;
        #1;
        chk({tag, " req_ready"}, 64'(rdy[d]), 64'(exp_rdy));
        id = 0;
        ea = '0;
        eb = '0;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) id = i;
        if (exp_rdy != '0) begin
            ea     = a[id*BW +: BW];
            eb     = b[id*BW +: BW];
            e.ie   = cyc + 1;
            e.id   = id;
            e.prod = {16'b0, ea} * {16'b0, eb};
            sbq[d].push_back(e);
        end
        chk({tag, " mul_A"}, 64'(ma[d]), 64'(ea));
        chk({tag, " mul_B"}, 64'(mb[d]), 64'(eb));
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) step(d, '0, '0, '0, '0, "idle");
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESETn = 1'b0;
        vld[0] = '1;
        vld[1] = '1;
        sbq[0].delete();
        sbq[1].delete();
        #1;
        chk("reset req_ready0", 64'(rdy[0]), 64'(0));
        chk("reset req_ready1", 64'(rdy[1]), 64'(0));
        chk("reset mul_A0", 64'(ma[0]), 64'(0));
        chk("reset rsp_valid0", 64'(rspv[0]), 64'(0));
        chk("reset rsp_valid1", 64'(rspv[1]), 64'(0));
        chk("reset inflight1", 64'(inf1), 64'(0));
        chk("reset inflight3", 64'(inf3), 64'(0));
        vld[0] = '0;
        vld[1] = '0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RESETn = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] eg;
        vld[0] = '0; vld[1] = '0;
        ra[0]  = '0; ra[1]  = '0;
        rb[0]  = '0; rb[1]  = '0;

        do_reset();

        // Single request from requester 2: 3*7
        step(0, 4'b0100, pack4(16'h0, 16'h0, 16'h3, 16'h0), pack4(16'h0, 16'h0, 16'h7, 16'h0),
             4'b0100, "single");
        idle(0, 3);

        // All four valid for 8 cycles, operands (i+1, 10)
        do_reset();
        for (int c = 0; c < 8; c++) begin
`ifdef MULT_SHARE_ARB_PRIO_EN
            eg = 4'b0001;
`else
            eg = NR'(1) << (c % NR);
`endif
            step(0, 4'b1111, pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd10, 16'd10, 16'd10, 16'd10),
                 eg, "all4");
        end
        idle(0, 3);

        // Maximum operands
        step(0, 4'b0001, pack4(16'hFFFF, 16'h0, 16'h0, 16'h0), pack4(16'hFFFF, 16'h0, 16'h0, 16'h0),
             4'b0001, "maxop");
        idle(0, 3);

        // LAT=3: ids 1, 3, 0 on consecutive cycles
        do_reset();
        step(1, 4'b0010, pack4(16'd0, 16'd5, 16'd0, 16'd0), pack4(16'd0, 16'd6, 16'd0, 16'd0),
             4'b0010, "lat3 id1");
        step(1, 4'b1000, pack4(16'd0, 16'd0, 16'd0, 16'd7), pack4(16'd0, 16'd0, 16'd0, 16'd8),
             4'b1000, "lat3 id3");
        step(1, 4'b0001, pack4(16'd9, 16'd0, 16'd0, 16'd0), pack4(16'd11, 16'd0, 16'd0, 16'd0),
             4'b0001, "lat3 id0");
        idle(1, 6);

        // LAT=3: reset while two products are in flight
        do_reset();
        step(1, 4'b0011, pack4(16'd2, 16'd3, 16'd0, 16'd0), pack4(16'd4, 16'd5, 16'd0, 16'd0),
             4'b0001, "midrst a");
        step(1, 4'b0110, pack4(16'd0, 16'd6, 16'd7, 16'd0), pack4(16'd0, 16'd8, 16'd9, 16'd0),
             4'b0010, "midrst b");
        do_reset();
        idle(1, 5);
        step(1, 4'b0110, pack4(16'd0, 16'd12, 16'd13, 16'd0), pack4(16'd0, 16'd2, 16'd2, 16'd0),
             4'b0010, "post reset");
        idle(1, 5);

        // Requesters 1 and 2 valid continuously
        do_reset();
        for (int c = 0; c < 4; c++) begin
`ifdef MULT_SHARE_ARB_PRIO_EN
            eg = 4'b0010;
`else
            eg = (c % 2 == 0) ? 4'b0010 : 4'b0100;
`endif
            step(0, 4'b0110, pack4(16'd0, 16'd21, 16'd22, 16'd0), pack4(16'd0, 16'd3, 16'd4, 16'd0),
                 eg, "pair12");
        end
        idle(0, 3);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard0 drained", 64'(sbq[0].size()), 64'(0));
        chk("scoreboard1 drained", 64'(sbq[1].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
